// File: rtl/rv_pkg.sv
// Shared RV32 encoding constants for the instruction packer: opcodes, format codes,
// immediate ranges and the decoded-field bundle type.
package rv_pkg;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_S = 7'b0100011;
    localparam logic [6:0] OP_B = 7'b1100011;

    typedef enum logic [1:0] {
        FMT_R = 2'd0,
        FMT_I = 2'd1,
        FMT_S = 2'd2,
        FMT_B = 2'd3
    } fmt_e;

    // I/S carry a 12-bit signed immediate; B carries a 13-bit even byte offset.
    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int IMM13_MIN = -4096;
    localparam int IMM13_MAX = 4094;

    typedef struct packed {
        fmt_e        fmt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } fields_t;

endpackage

// File: rtl/instr_packer_if.sv
// Loader-side field bundle handshake plus instruction-memory write port of the packer.
interface instr_packer_if;

    logic        in_valid_i;
    logic        in_ready_o;
    logic [1:0]  fmt_i;
    logic [4:0]  rd_i;
    logic [4:0]  rs1_i;
    logic [4:0]  rs2_i;
    logic [2:0]  funct3_i;
    logic [6:0]  funct7_i;
    logic [31:0] imm_i;

    logic        mem_we_o;
    logic        mem_ready_i;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;

    modport slave (
        input  in_valid_i, fmt_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i, mem_ready_i,
        output in_ready_o, mem_we_o, mem_addr_o, mem_data_o
    );

    modport master (
        output in_valid_i, fmt_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i, mem_ready_i,
        input  in_ready_o, mem_we_o, mem_addr_o, mem_data_o
    );

endinterface

// File: rtl/instr_pack_comb.sv
// Pure combinational RV32 R/I/S/B encoder with immediate range check.
// o_ok low means the bundle must be rejected; o_word is then meaningless.
module instr_pack_comb
    import rv_pkg::*;
(
    input  fields_t     i_fields,
    output logic [31:0] o_word,
    output logic        o_ok
);

    logic signed [31:0] w_imm;
    logic               w_in12;
    logic               w_in13;

    assign w_imm  = signed'(i_fields.imm);
    assign w_in12 = (w_imm >= IMM12_MIN) && (w_imm <= IMM12_MAX);
    assign w_in13 = (w_imm >= IMM13_MIN) && (w_imm <= IMM13_MAX);

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        o_word = '0;
        o_ok   = 1'b1;
        case (i_fields.fmt)
            FMT_R: begin
                o_word = {i_fields.funct7, i_fields.rs2, i_fields.rs1,
                          i_fields.funct3, i_fields.rd, OP_R};
            end
            FMT_I: begin
                o_word = {i_fields.imm[11:0], i_fields.rs1,
                          i_fields.funct3, i_fields.rd, OP_I};
                o_ok   = w_in12;
            end
            FMT_S: begin
                o_word = {i_fields.imm[11:5], i_fields.rs2, i_fields.rs1,
                          i_fields.funct3, i_fields.imm[4:0], OP_S};
                o_ok   = w_in12;
            end
            FMT_B: begin
                o_word = {i_fields.imm[12], i_fields.imm[10:5], i_fields.rs2, i_fields.rs1,
                          i_fields.funct3, i_fields.imm[4:1], i_fields.imm[11], OP_B};
                o_ok   = w_in13 && !i_fields.imm[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_packer.sv
// Packs decoded field bundles into RV32 words and streams them into instruction memory
// through a single output register; out-of-range immediates are dropped and counted.
module instr_packer
    import rv_pkg::*;
#(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          CNT_W     = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    instr_packer_if.slave     bus,
    output logic              err_o,
    output logic [CNT_W-1:0]  err_cnt_o,
    output logic              full_o
);

    localparam int             WC_W    = $clog2(DEPTH) + 1;
    localparam logic [WC_W-1:0] WC_FULL = WC_W'(DEPTH);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(DEPTH - 1);

    fields_t           w_fields;
    logic [31:0]       w_word;
    logic              w_ok;
    logic              w_accept;
    logic              w_done;
    logic              w_last;

    logic              r_we;
    logic [31:0]       r_addr;
    logic [31:0]       r_data;
    logic              r_err;
    logic [CNT_W-1:0]  r_err_cnt;
    logic [WC_W-1:0]   r_count;

    assign w_fields = '{
        fmt:    fmt_e'(bus.fmt_i),
        rd:     bus.rd_i,
        rs1:    bus.rs1_i,
        rs2:    bus.rs2_i,
        funct3: bus.funct3_i,
        funct7: bus.funct7_i,
        imm:    bus.imm_i
    };

    instr_pack_comb u_pack (
        .i_fields (w_fields),
        .o_word   (w_word),
        .o_ok     (w_ok)
    );

    assign full_o = (r_count == WC_FULL);
    assign w_done = r_we && bus.mem_ready_i;
    assign w_last = (r_count == WC_LAST);

    // While the final word is completing, a new bundle would be word DEPTH+1, so hold it off.
    assign bus.in_ready_o = !full_o && (!r_we || (bus.mem_ready_i && !w_last));
    assign w_accept       = bus.in_valid_i && bus.in_ready_o;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_we      <= 1'b0;
            r_addr    <= BASE_ADDR;
            r_data    <= '0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
            r_count   <= '0;
        end else begin
            r_we  <= (w_accept && w_ok) || (r_we && !bus.mem_ready_i);
            r_err <= w_accept && !w_ok;
            if (w_accept && w_ok) begin
                r_data <= w_word;
            end
            if (w_done) begin
                r_addr  <= r_addr + 32'd4;
                r_count <= r_count + WC_W'(1);
            end
            if (w_accept && !w_ok && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.mem_we_o   = r_we;
    assign bus.mem_addr_o = r_addr;
    assign bus.mem_data_o = r_data;
    assign err_o          = r_err;
    assign err_cnt_o      = r_err_cnt;

endmodule

// File: tb/tb_instr_packer.sv
// Self-checking bench for instr_packer: table of field bundles with expected words,
// a write scoreboard, and directed sequences for stall, full, saturation and reset.
module tb_instr_packer;
    import rv_pkg::*;

    localparam int DEPTH   = 4;
    localparam int CNT_W   = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             clear_i;
    logic             err_o;
    logic [CNT_W-1:0] err_cnt_o;
    logic             full_o;

    instr_packer_if bus ();

    instr_packer #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (32'h0),
        .CNT_W     (CNT_W)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .clear_i   (clear_i),
        .bus       (bus.slave),
        .err_o     (err_o),
        .err_cnt_o (err_cnt_o),
        .full_o    (full_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  fmt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        bit          ok;
        logic [31:0] word;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    int          checks = 0;
    int          errors = 0;
    wr_t         sb[$];
    logic [31:0] exp_addr = 32'h0;
    int          exp_words = 0;
    int          exp_cnt = 0;
    int          exp_err = 0;
    int          err_seen = 0;
    int          writes_seen = 0;
    bit          rand_mode = 1'b0;
    vec_t        tbl[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %0s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Write monitor: pops the scoreboard on every completed handshake and checks hold stability.
    logic        p_hold;
    logic [31:0] p_addr;
    logic [31:0] p_data;
    always @(negedge clk) begin
        if (err_o === 1'b1) err_seen++;
        if (rst_i === 1'b0 && clear_i === 1'b0) begin
            if (p_hold === 1'b1) begin
                check("hold_we", {31'b0, bus.mem_we_o}, 32'd1);
                check("hold_addr", bus.mem_addr_o, p_addr);
                check("hold_data", bus.mem_data_o, p_data);
            end
            if (bus.mem_we_o === 1'b1 && bus.mem_ready_i === 1'b1) begin
                writes_seen++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, none expected",
                             bus.mem_addr_o, bus.mem_data_o);
                end else begin
                    wr_t e;
                    e = sb.pop_front();
                    check("wr_addr", bus.mem_addr_o, e.addr);
                    check("wr_data", bus.mem_data_o, e.data);
                end
            end
        end
        p_hold = bus.mem_we_o && !bus.mem_ready_i && !rst_i && !clear_i;
        p_addr = bus.mem_addr_o;
        p_data = bus.mem_data_o;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_mode) bus.mem_ready_i = ($urandom_range(0, 3) != 0);
    endtask

    task automatic drive(input vec_t v);
        bus.fmt_i    = v.fmt;
        bus.rd_i     = v.rd;
        bus.rs1_i    = v.rs1;
        bus.rs2_i    = v.rs2;
        bus.funct3_i = v.f3;
        bus.funct7_i = v.f7;
        bus.imm_i    = v.imm;
    endtask

    task automatic model_accept(input vec_t v);
        if (v.ok) begin
            sb.push_back('{exp_addr, v.word});
            exp_addr += 32'd4;
            exp_words++;
        end else begin
            exp_err++;
            if (exp_cnt != CNT_MAX) exp_cnt++;
        end
    endtask

    task automatic send(input vec_t v, output bit acc);
        acc = 1'b0;
        drive(v);
        bus.in_valid_i = 1'b1;
        for (int i = 0; i < 40 && !acc; i++) begin
            @(negedge clk);
            acc = bus.in_ready_o;
            tick();
        end
        bus.in_valid_i = 1'b0;
        if (acc) model_accept(v);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
        check("drain_empty", sb.size(), 32'd0);
        tick();
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        sb.delete();
        tick();
        clear_i   = 1'b0;
        exp_addr  = 32'h0;
        exp_words = 0;
        exp_cnt   = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1);
    end

    initial begin
        bit   acc;
        int   base_w;
        int   base_e;
        vec_t v;

        //           fmt   rd     rs1    rs2    f3    f7      imm            ok    word
        tbl[0]  = '{2'd2, 5'd31, 5'd2, 5'd5,  3'd2, 7'h00, -4,            1'b1, 32'hFE512E23};
        tbl[1]  = '{2'd3, 5'd0,  5'd1, 5'd2,  3'd0, 7'h00, 8,             1'b1, 32'h00208463};
        tbl[2]  = '{2'd1, 5'd1,  5'd0, 5'd31, 3'd0, 7'h7F, -1,            1'b1, 32'hFFF00093};
        tbl[3]  = '{2'd0, 5'd3,  5'd1, 5'd2,  3'd0, 7'h00, 0,             1'b1, 32'h002081B3};
        tbl[4]  = '{2'd0, 5'd5,  5'd6, 5'd7,  3'd0, 7'h20, 0,             1'b1, 32'h407302B3};
        tbl[5]  = '{2'd1, 5'd2,  5'd3, 5'd0,  3'd0, 7'h00, 2047,          1'b1, 32'h7FF18113};
        tbl[6]  = '{2'd1, 5'd0,  5'd0, 5'd0,  3'd0, 7'h00, -2048,         1'b1, 32'h80000013};
        tbl[7]  = '{2'd2, 5'd0,  5'd0, 5'd0,  3'd0, 7'h00, 2047,          1'b1, 32'h7E000FA3};
        tbl[8]  = '{2'd3, 5'd0,  5'd0, 5'd0,  3'd0, 7'h00, -4096,         1'b1, 32'h80000063};
        tbl[9]  = '{2'd3, 5'd0,  5'd0, 5'd0,  3'd0, 7'h00, 4094,          1'b1, 32'h7E000FE3};
        tbl[10] = '{2'd0, 5'd1,  5'd2, 5'd3,  3'd7, 7'h00, 32'h7FFFFFFF,  1'b1, 32'h003170B3};
        tbl[11] = '{2'd3, 5'd0,  5'd1, 5'd2,  3'd0, 7'h00, 7,             1'b0, 32'h0};
        tbl[12] = '{2'd1, 5'd1,  5'd0, 5'd0,  3'd0, 7'h00, 2048,          1'b0, 32'h0};
        tbl[13] = '{2'd2, 5'd0,  5'd0, 5'd0,  3'd0, 7'h00, -2049,         1'b0, 32'h0};
        tbl[14] = '{2'd3, 5'd0,  5'd0, 5'd0,  3'd0, 7'h00, 4096,          1'b0, 32'h0};
        tbl[15] = '{2'd3, 5'd0,  5'd0, 5'd0,  3'd0, 7'h00, -4098,         1'b0, 32'h0};
        tbl[16] = '{2'd1, 5'd0,  5'd0, 5'd0,  3'd0, 7'h00, 32'h80000000,  1'b0, 32'h0};

        rst_i           = 1'b1;
        clear_i         = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.mem_ready_i = 1'b1;
        drive(tbl[3]);
        repeat (2) tick();

        check("rst_we",       {31'b0, bus.mem_we_o},   32'd0);
        check("rst_addr",     bus.mem_addr_o,          32'h0);
        check("rst_data",     bus.mem_data_o,          32'h0);
        check("rst_err",      {31'b0, err_o},          32'd0);
        check("rst_err_cnt",  {29'b0, err_cnt_o},      32'd0);
        check("rst_full",     {31'b0, full_o},         32'd0);
        check("rst_in_ready", {31'b0, bus.in_ready_o}, 32'd1);
        rst_i = 1'b0;
        tick();

        // Two rejected bundles: no writes, two error pulses, address untouched.
        base_e = err_seen;
        send(tbl[11], acc);
        check("err1_accept", {31'b0, acc}, 32'd1);
        send(tbl[12], acc);
        check("err2_accept", {31'b0, acc}, 32'd1);
        repeat (2) tick();
        check("err_cnt_two",   {29'b0, err_cnt_o}, 32'd2);
        check("err_pulses",    err_seen - base_e,  32'd2);
        check("err_addr_same", bus.mem_addr_o,     32'h0);
        check("err_no_writes", writes_seen,        32'd0);

        // One-cycle latency from accept to mem_we_o.
        send(tbl[0], acc);
        check("lat_accept", {31'b0, acc},          32'd1);
        check("lat_we",     {31'b0, bus.mem_we_o}, 32'd1);
        check("lat_data",   bus.mem_data_o,        32'hFE512E23);
        check("lat_addr",   bus.mem_addr_o,        32'h0);
        drain();

        // Table sweep with random memory back-pressure; rewind whenever memory fills.
        rand_mode = 1'b1;
        base_e    = err_seen;
        exp_err   = 0;
        for (int i = 1; i < 17; i++) begin
            send(tbl[i], acc);
            check("tbl_accept", {31'b0, acc}, 32'd1);
            if (exp_words == DEPTH) begin
                drain();
                check("tbl_full",     {31'b0, full_o},         32'd1);
                check("tbl_full_rdy", {31'b0, bus.in_ready_o}, 32'd0);
                check("tbl_err_cnt",  {29'b0, err_cnt_o},      exp_cnt);
                do_clear();
            end
        end
        rand_mode       = 1'b0;
        bus.mem_ready_i = 1'b1;
        drain();
        check("tbl_err_pulses", err_seen - base_e,  exp_err);
        check("tbl_err_cnt_end", {29'b0, err_cnt_o}, exp_cnt);

        // Memory stalls three cycles: word held, loader blocked, exactly one write.
        do_clear();
        base_w          = writes_seen;
        bus.mem_ready_i = 1'b0;
        send(tbl[3], acc);
        check("stall_accept", {31'b0, acc}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            check("stall_we",    {31'b0, bus.mem_we_o},   32'd1);
            check("stall_ready", {31'b0, bus.in_ready_o}, 32'd0);
            check("stall_data",  bus.mem_data_o,          32'h002081B3);
            tick();
        end
        bus.mem_ready_i = 1'b1;
        repeat (2) tick();
        check("stall_we_after", {31'b0, bus.mem_we_o}, 32'd0);
        check("stall_writes",   writes_seen - base_w,  32'd1);
        check("stall_addr",     bus.mem_addr_o,        32'h4);

        // Five bundles streamed continuously into a DEPTH-word memory.
        do_clear();
        begin
            int acc_n;
            int first_w;
            int last_w;
            int nw;
            acc_n   = 0;
            first_w = -1;
            last_w  = -1;
            nw      = 0;
            v = '{2'd1, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 0, 1'b1, 32'h00000013};
            drive(v);
            bus.in_valid_i = 1'b1;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (bus.mem_we_o && bus.mem_ready_i) begin
                    if (first_w < 0) first_w = c;
                    last_w = c;
                    nw++;
                end
                acc = bus.in_ready_o;
                tick();
                if (acc) begin
                    model_accept(v);
                    acc_n++;
                    v.rd   = 5'(acc_n);
                    v.imm  = acc_n;
                    v.word = (32'(acc_n) << 20) | (32'(acc_n) << 7) | 32'h13;
                    drive(v);
                end
            end
            bus.in_valid_i = 1'b0;
            check("full_accepts",  acc_n,                    32'd4);
            check("full_writes",   nw,                       32'd4);
            check("full_b2b",      last_w - first_w,         32'd3);
            check("full_flag",     {31'b0, full_o},          32'd1);
            check("full_ready",    {31'b0, bus.in_ready_o},  32'd0);
            check("full_addr",     bus.mem_addr_o,           32'h10);
        end

        // Error counter saturates at all-ones.
        do_clear();
        check("clear_full",  {31'b0, full_o},    32'd0);
        check("clear_addr",  bus.mem_addr_o,     32'h0);
        base_e = err_seen;
        base_w = writes_seen;
        for (int k = 0; k < CNT_MAX + 2; k++) begin
            send(tbl[13], acc);
            check("sat_accept", {31'b0, acc}, 32'd1);
        end
        repeat (2) tick();
        check("sat_err_cnt", {29'b0, err_cnt_o}, CNT_MAX);
        check("sat_pulses",  err_seen - base_e,  CNT_MAX + 2);
        check("sat_writes",  writes_seen - base_w, 32'd0);

        // Reset while a write is stalled: pending word dropped, state back to reset values.
        bus.mem_ready_i = 1'b0;
        send(tbl[5], acc);
        check("rstw_accept", {31'b0, acc},          32'd1);
        check("rstw_we",     {31'b0, bus.mem_we_o}, 32'd1);
        rst_i = 1'b1;
        sb.delete();
        tick();
        check("rstw_we_off",  {31'b0, bus.mem_we_o}, 32'd0);
        check("rstw_addr",    bus.mem_addr_o,        32'h0);
        check("rstw_err_cnt", {29'b0, err_cnt_o},    32'd0);
        check("rstw_data",    bus.mem_data_o,        32'h0);
        rst_i           = 1'b0;
        bus.mem_ready_i = 1'b1;
        base_w          = writes_seen;
        repeat (3) tick();
        check("rstw_no_write", writes_seen - base_w, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
